thumb_decode_stage: RTL and testbench

- Next-generation Thumb decode stage: halfword-stream decoder with valid/ready handshakes on both sides and an output FIFO.
- Assembles 32-bit Thumb-2 instructions from two halfwords; only BL is decoded, every other 32-bit encoding is flagged invalid.
- Sign-extends branch offsets and supports pipeline flush.
- Sits between the fetch unit (halfword source) and the register-read/execute stage.

---
 rtl/thumb_decode_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_thumb_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_decode_stage.sv
// Thumb decode stage: takes a halfword stream, assembles 16/32-bit Thumb
// instructions, decodes them into micro-op fields and queues the results
// in a small output FIFO for the register-read stage.
module thumb_decode_stage #(
  parameter int NUM_W      = 32,
  parameter int SEL_W      = 4,
  parameter int DEPTH      = 2,
  parameter int LDST_SCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       uop,
  output logic             num_to_rhs,
  output logic [NUM_W-1:0] num,
  output logic [SEL_W-1:0] sel_p0,
  output logic [SEL_W-1:0] sel_p1,
  output logic [SEL_W-1:0] sel_in,
  output logic             explose,
  output logic [3:0]       branch_cond
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Widest offset is 24 bits (BL); narrower num outputs keep the low bits.
  localparam int OW = (NUM_W < 24) ? NUM_W : 24;

  typedef struct packed {
    logic [4:0]       uop;
    logic             rhs;
    logic [NUM_W-1:0] num;
    logic [SEL_W-1:0] p0;
    logic [SEL_W-1:0] p1;
    logic [SEL_W-1:0] rd;
    logic             explose;
    logic [3:0]       cond;
  } entry_t;

  typedef enum logic {IDLE, HW2} state_t;

  function automatic logic [NUM_W-1:0] sext24(input logic [23:0] v);
    logic [NUM_W-1:0] r;
    r = {NUM_W{v[23]}};
    r[OW-1:0] = v[OW-1:0];
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] rs(input logic [2:0] f);
    return SEL_W'(f);
  endfunction

  function automatic logic [NUM_W-1:0] ldst_imm(input logic [4:0] i5);
    return (LDST_SCALE != 0) ? NUM_W'({i5, 2'b00}) : NUM_W'(i5);
  endfunction

  function automatic entry_t decode16(input logic [15:0] h);
    entry_t e;
    e      = '0;
    e.cond = 4'hF;
    if (h[15:10] == 6'b000110) begin          // ADD/SUB register
      e.uop = h[9] ? 5'd2 : 5'd1;
      e.p0  = rs(h[8:6]);
      e.p1  = rs(h[5:3]);
      e.rd  = rs(h[2:0]);
    end else if (h[15:10] == 6'b000111) begin // ADD/SUB imm3
      e.uop = h[9] ? 5'd2 : 5'd1;
      e.num = NUM_W'(h[8:6]);
      e.p1  = rs(h[5:3]);
      e.rd  = rs(h[2:0]);
      e.rhs = 1'b1;
    end else if (h[15:12] == 4'b0011) begin   // ADD/SUB imm8
      e.uop = h[11] ? 5'd2 : 5'd1;
      e.p1  = rs(h[10:8]);
      e.rd  = rs(h[10:8]);
      e.num = NUM_W'(h[7:0]);
      e.rhs = 1'b1;
    end else if (h[15:11] == 5'b00000) begin
      if (h[10:6] == 5'd0) begin              // MOV register
        e.uop = 5'd8;
        e.p0  = rs(h[5:3]);
        e.rd  = rs(h[2:0]);
      end else begin                          // LSL imm
        e.uop = 5'd6;
        e.num = NUM_W'(h[10:6]);
        e.p1  = rs(h[5:3]);
        e.rd  = rs(h[2:0]);
        e.rhs = 1'b1;
      end
    end else if (h[15:11] == 5'b00100) begin  // MOV imm
      e.uop = 5'd8;
      e.rd  = rs(h[10:8]);
      e.num = NUM_W'(h[7:0]);
      e.rhs = 1'b1;
    end else if (h[15:11] == 5'b00101) begin  // CMP imm
      e.uop = 5'd5;
      e.p1  = rs(h[10:8]);
      e.num = NUM_W'(h[7:0]);
      e.rhs = 1'b1;
    end else if (h[15:6] == 10'b0100000001) begin // EOR
      e.uop = 5'd4;
      e.p0  = rs(h[2:0]);
      e.rd  = rs(h[2:0]);
      e.p1  = rs(h[5:3]);
    end else if (h[15:12] == 4'b0110) begin   // STR/LDR imm5
      e.num = ldst_imm(h[10:6]);
      e.p1  = rs(h[5:3]);
      e.rhs = 1'b1;
      if (h[11]) begin
        e.uop = 5'd10;
        e.rd  = rs(h[2:0]);
      end else begin
        e.uop = 5'd9;
        e.p0  = rs(h[2:0]);
      end
    end else if (h[15:12] == 4'b1101 && h[11:9] != 3'b111) begin // B<cond>
      e.cond = h[11:8];
      e.num  = sext24({{16{h[7]}}, h[7:0]});
    end else if (h[15:11] == 5'b11100) begin  // B
      e.cond = 4'hE;
      e.num  = sext24({{13{h[10]}}, h[10:0]});
    end else begin
      e.explose = 1'b1;
    end
    return e;
  endfunction

  function automatic entry_t decode32(input logic [15:0] h1, input logic [15:0] h2);
    entry_t e;
    logic   s, i1, i2;
    e      = '0;
    e.cond = 4'hF;
    s      = h1[10];
    i1     = ~(h2[13] ^ s);
    i2     = ~(h2[11] ^ s);
    if (h1[15:11] == 5'b11110 && h2[15:14] == 2'b11 && h2[12]) begin
      e.uop  = 5'd11;
      e.cond = 4'hE;
      e.rd   = SEL_W'(4'd14);
      e.num  = sext24({s, i1, i2, h1[9:0], h2[10:0]});
    end else begin
      e.explose = 1'b1;
    end
    return e;
  endfunction

  state_t         state_q, state_d;
  logic [15:0]    hw1_q, hw1_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  entry_t         mem_q [DEPTH];
  entry_t         push_e, head, idle_e;
  logic           push, pop, accept, is_prefix;

  assign in_ready  = (cnt_q < CW'(DEPTH)) && !flush;
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign is_prefix = (instruction[15:13] == 3'b111) && (instruction[12:11] != 2'b00);

  // Halfword assembly FSM: decides what (if anything) is pushed this cycle
  always_comb begin
    state_d = state_q;
    hw1_d   = hw1_q;
    push    = 1'b0;
    push_e  = decode16(instruction);
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (is_prefix) begin
            state_d = HW2;
            hw1_d   = instruction;
          end else begin
            push = 1'b1;
          end
        end
        HW2: begin
          push    = 1'b1;
          push_e  = decode32(hw1_q, instruction);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointer/occupancy next state; flush empties the queue outright
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hw1_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hw1_q   <= hw1_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents are masked by cnt_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_e;
  end

  // Idle output values shown whenever the FIFO is empty
  always_comb begin
    idle_e      = '0;
    idle_e.cond = 4'hF;
  end

  assign head        = out_valid ? mem_q[rd_q] : idle_e;
  assign uop         = head.uop;
  assign num_to_rhs  = head.rhs;
  assign num         = head.num;
  assign sel_p0      = head.p0;
  assign sel_p1      = head.p1;
  assign sel_in      = head.rd;
  assign explose     = head.explose;
  assign branch_cond = head.cond;

endmodule

// File: tb/tb_thumb_decode_stage.sv
// Bench for thumb_decode_stage: fixed decode vectors, handshake/flush/reset
// sequences, then random traffic against a queue-based reference model.
module tb_thumb_decode_stage;

  typedef struct packed {
    logic [4:0]  uop;
    logic        rhs;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  rd;
    logic        exp;
    logic [3:0]  cond;
  } ent_t;

  typedef struct {
    logic [15:0] hw;
    ent_t        e;
  } vec_t;

  localparam ent_t RST = '{5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'hF};
  localparam int   NV  = 17;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instruction;
  logic [4:0]  uop;
  logic        num_to_rhs, explose;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  ent_t        got;
  int          checks, fails;

  assign got = {uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, explose, branch_cond};

  thumb_decode_stage #(.NUM_W(32), .SEL_W(4), .DEPTH(2), .LDST_SCALE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .uop(uop), .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1),
    .sel_in(sel_in), .explose(explose), .branch_cond(branch_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t mk(int u, int r, logic [31:0] n, int a, int b, int d, int x, int c);
    ent_t e;
    e.uop = 5'(u); e.rhs = 1'(r); e.num = n; e.p0 = 4'(a); e.p1 = 4'(b);
    e.rd = 4'(d); e.exp = 1'(x); e.cond = 4'(c);
    return e;
  endfunction

  // Reference decode of one 16-bit instruction, from the opcode table
  function automatic ent_t ref16(logic [15:0] h);
    ent_t e;
    int top7, top5, top10, a, b, c, hi3, i8, i5, i11, v;
    top7 = int'(h[15:9]); top5 = int'(h[15:11]); top10 = int'(h[15:6]);
    a = int'(h[8:6]); b = int'(h[5:3]); c = int'(h[2:0]); hi3 = int'(h[10:8]);
    i8 = int'(h[7:0]); i5 = int'(h[10:6]); i11 = int'(h[10:0]);
    e = RST;
    if (top7 >= 12 && top7 <= 15) begin
      e.uop = (top7 % 2 == 1) ? 5'd2 : 5'd1;
      e.p1 = 4'(b); e.rd = 4'(c);
      if (top7 >= 14) begin e.num = 32'(a); e.rhs = 1; end
      else e.p0 = 4'(a);
    end else if (top5 == 6 || top5 == 7) begin
      e.uop = (top5 == 7) ? 5'd2 : 5'd1;
      e.p1 = 4'(hi3); e.rd = 4'(hi3); e.num = 32'(i8); e.rhs = 1;
    end else if (top5 == 0) begin
      if (i5 == 0) begin e.uop = 8; e.p0 = 4'(b); e.rd = 4'(c); end
      else begin e.uop = 6; e.num = 32'(i5); e.p1 = 4'(b); e.rd = 4'(c); e.rhs = 1; end
    end else if (top5 == 4) begin
      e.uop = 8; e.rd = 4'(hi3); e.num = 32'(i8); e.rhs = 1;
    end else if (top5 == 5) begin
      e.uop = 5; e.p1 = 4'(hi3); e.num = 32'(i8); e.rhs = 1;
    end else if (top10 == 257) begin
      e.uop = 4; e.p0 = 4'(c); e.rd = 4'(c); e.p1 = 4'(b);
    end else if (top5 == 12 || top5 == 13) begin
      e.num = 32'(i5 * 4); e.p1 = 4'(b); e.rhs = 1;
      if (top5 == 13) begin e.uop = 10; e.rd = 4'(c); end
      else begin e.uop = 9; e.p0 = 4'(c); end
    end else if (int'(h[15:12]) == 13 && int'(h[11:8]) < 14) begin
      e.uop = 0; e.cond = h[11:8];
      v = (i8 > 127) ? i8 - 256 : i8;
      e.num = 32'(v);
    end else if (top5 == 28) begin
      e.uop = 0; e.cond = 4'hE;
      v = (i11 > 1023) ? i11 - 2048 : i11;
      e.num = 32'(v);
    end else begin
      e.exp = 1;
    end
    return e;
  endfunction

  // Reference decode of a 32-bit pair: only BL is recognised
  function automatic ent_t ref32(logic [15:0] h1, logic [15:0] h2);
    ent_t e;
    int s, j1, j2, i1, i2, off;
    e = RST;
    if (int'(h1[15:11]) == 30 && int'(h2[15:14]) == 3 && h2[12] == 1'b1) begin
      s = int'(h1[10]); j1 = int'(h2[13]); j2 = int'(h2[11]);
      i1 = (j1 == s) ? 1 : 0;
      i2 = (j2 == s) ? 1 : 0;
      off = s * (1 << 23) + i1 * (1 << 22) + i2 * (1 << 21)
          + int'(h1[9:0]) * (1 << 11) + int'(h2[10:0]);
      if (s == 1) off = off - (1 << 24);
      e.uop = 11; e.cond = 4'hE; e.rd = 4'd14; e.num = 32'(off);
    end else begin
      e.exp = 1;
    end
    return e;
  endfunction

  task automatic chk_bit(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_ent(string nm, ent_t exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got uop=%0d rhs=%0b num=%h p0=%0d p1=%0d in=%0d exp=%0b cond=%h want uop=%0d rhs=%0b num=%h p0=%0d p1=%0d in=%0d exp=%0b cond=%h",
               nm, got.uop, got.rhs, got.num, got.p0, got.p1, got.rd, got.exp, got.cond,
               exp.uop, exp.rhs, exp.num, exp.p0, exp.p1, exp.rd, exp.exp, exp.cond);
    end
  endtask

  task automatic check_head(string nm, ent_t e);
    chk_bit({nm, " out_valid"}, out_valid, 1'b1);
    chk_ent(nm, e);
  endtask

  task automatic check_empty(string nm);
    chk_bit({nm, " out_valid"}, out_valid, 1'b0);
    chk_ent(nm, RST);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl [NV];
    ent_t        q[$];
    ent_t        tmp;
    logic        pend, fl, iv, ordy, acc;
    logic [15:0] hw, hw1m;
    int          r;

    checks = 0; fails = 0;
    tbl[0]  = '{16'h1888, mk(1, 0, 0, 2, 1, 0, 0, 15)};
    tbl[1]  = '{16'hD0FE, mk(0, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 0)};
    tbl[2]  = '{16'hE7FF, mk(0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 14)};
    tbl[3]  = '{16'h2005, mk(8, 1, 5, 0, 0, 0, 0, 15)};
    tbl[4]  = '{16'hB000, mk(0, 0, 0, 0, 0, 0, 1, 15)};
    tbl[5]  = '{16'h1E8A, mk(2, 1, 2, 0, 1, 2, 0, 15)};
    tbl[6]  = '{16'h3A7F, mk(2, 1, 127, 0, 2, 2, 0, 15)};
    tbl[7]  = '{16'h0048, mk(6, 1, 1, 0, 1, 0, 0, 15)};
    tbl[8]  = '{16'h0011, mk(8, 0, 0, 2, 0, 1, 0, 15)};
    tbl[9]  = '{16'h2B10, mk(5, 1, 16, 0, 3, 0, 0, 15)};
    tbl[10] = '{16'h405A, mk(4, 0, 0, 2, 3, 2, 0, 15)};
    tbl[11] = '{16'h6A4B, mk(10, 1, 36, 0, 1, 3, 0, 15)};
    tbl[12] = '{16'h6013, mk(9, 1, 0, 3, 2, 0, 0, 15)};
    tbl[13] = '{16'hDE00, mk(0, 0, 0, 0, 0, 0, 1, 15)};
    tbl[14] = '{16'hD17F, mk(0, 0, 127, 0, 0, 0, 0, 1)};
    tbl[15] = '{16'h1C53, mk(1, 1, 1, 0, 2, 3, 0, 15)};
    tbl[16] = '{16'h3480, mk(1, 1, 128, 0, 4, 4, 0, 15)};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    #2;
    check_empty("in reset");
    chk_bit("in reset in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_empty("after reset");

    // Single 16-bit decodes, each pushed then popped
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; instruction = tbl[i].hw;
      tick;
      in_valid = 1'b0;
      check_head($sformatf("vec%0d %h", i, tbl[i].hw), tbl[i].e);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check_empty($sformatf("vec%0d pop", i));
    end

    // BL pairs: nothing visible after the prefix
    in_valid = 1'b1; instruction = 16'hF7FF;
    tick;
    chk_bit("bl hw1 no output", out_valid, 1'b0);
    instruction = 16'hFFFF;
    tick;
    in_valid = 1'b0;
    check_head("bl neg", mk(11, 0, 32'hFFFFFFFF, 0, 0, 14, 0, 14));
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check_empty("bl neg pop");
    in_valid = 1'b1; instruction = 16'hF000;
    tick;
    instruction = 16'hD001;
    tick;
    in_valid = 1'b0;
    check_head("bl pos", mk(11, 0, 32'h00600001, 0, 0, 14, 0, 14));
    out_ready = 1'b1; tick; out_ready = 1'b0;

    // Backpressure: FIFO fills, third halfword held, drain in order
    in_valid = 1'b1; instruction = 16'h2005;
    tick;
    instruction = 16'h2106;
    tick;
    instruction = 16'h2207;
    chk_bit("full in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk_bit("full pop no ready-through", in_ready, 1'b0);
    check_head("drain0", mk(8, 1, 5, 0, 0, 0, 0, 15));
    tick;
    chk_bit("drain in_ready", in_ready, 1'b1);
    check_head("drain1", mk(8, 1, 6, 0, 0, 1, 0, 15));
    tick;
    in_valid = 1'b0;
    check_head("drain2", mk(8, 1, 7, 0, 0, 2, 0, 15));
    tick;
    out_ready = 1'b0;
    check_empty("drained");

    // Flush drops a queued entry and a latched prefix
    in_valid = 1'b1; instruction = 16'h1888;
    tick;
    instruction = 16'hF000;
    tick;
    flush = 1'b1; instruction = 16'h1234; out_ready = 1'b1;
    #1;
    chk_bit("flush in_ready", in_ready, 1'b0);
    tick;
    flush = 1'b0; out_ready = 1'b0;
    check_empty("after flush");
    instruction = 16'h2005;
    tick;
    in_valid = 1'b0;
    check_head("flush then mov", mk(8, 1, 5, 0, 0, 0, 0, 15));
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check_empty("flush seq pop");

    // Unsupported 32-bit pair still yields exactly one entry
    in_valid = 1'b1; instruction = 16'hE800;
    tick;
    chk_bit("e800 no output", out_valid, 1'b0);
    instruction = 16'h0000;
    tick;
    in_valid = 1'b0;
    check_head("bad32", mk(0, 0, 0, 0, 0, 0, 1, 15));
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check_empty("bad32 pop");

    // Async reset in the middle of a 32-bit pair
    in_valid = 1'b1; instruction = 16'h2005;
    tick;
    instruction = 16'hF000;
    tick;
    in_valid = 1'b0;
    check_head("pre reset", mk(8, 1, 5, 0, 0, 0, 0, 15));
    #2 reset = 1'b1;
    #1;
    check_empty("async reset");
    chk_bit("async reset in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1; instruction = 16'h2005;
    tick;
    in_valid = 1'b0;
    check_head("post reset mov", mk(8, 1, 5, 0, 0, 0, 0, 15));
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check_empty("post reset pop");

    // Random traffic against the reference model
    q.delete(); pend = 1'b0; hw1m = '0;
    for (int n = 0; n < 400; n++) begin
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      r    = $urandom_range(0, 3);
      hw   = 16'($urandom);
      if (r == 0) hw[15:11] = 5'b11110;
      else if (r == 1 && pend) begin hw[15:14] = 2'b11; hw[12] = 1'b1; end
      flush = fl; in_valid = iv; out_ready = ordy; instruction = hw;
      #1;
      acc = iv && (q.size() < 2) && !fl;
      chk_bit("rnd in_ready", in_ready, (q.size() < 2) && !fl);
      @(posedge clk);
      if (fl) begin
        q.delete(); pend = 1'b0;
      end else begin
        if (ordy && q.size() > 0) tmp = q.pop_front();
        if (acc) begin
          if (pend) begin q.push_back(ref32(hw1m, hw)); pend = 1'b0; end
          else if (hw[15:11] >= 5'd29) begin pend = 1'b1; hw1m = hw; end
          else q.push_back(ref16(hw));
        end
      end
      #1;
      if (q.size() == 0) check_empty($sformatf("rnd%0d", n));
      else check_head($sformatf("rnd%0d", n), q[0]);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
